// File: rtl/ffram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port flip-flop RAM.
// Each access is GRANT (RAM driven) then ACK (registered pulse), then back to IDLE.
module ffram_arbiter #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned AD_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [AD_WIDTH-1:0] a_addr,
  input  logic [WORD_W-1:0]   a_wdata,
  input  logic [WORD_W-1:0]   a_ben,
  output logic                a_ack,
  output logic [WORD_W-1:0]   a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [AD_WIDTH-1:0] b_addr,
  input  logic [WORD_W-1:0]   b_wdata,
  input  logic [WORD_W-1:0]   b_ben,
  output logic                b_ack,
  output logic [WORD_W-1:0]   b_rdata,
  output logic [WORD_W-1:0]   ram_d_in,
  output logic [WORD_W-1:0]   ram_bit_en,
  output logic [AD_WIDTH-1:0] ram_addr,
  output logic                ram_wb_en,
  output logic                ram_r_en,
  input  logic [WORD_W-1:0]   ram_d_out,
  output logic                busy
);

  typedef enum logic [2:0] {StIdle, StGrantA, StGrantB, StAckA, StAckB} state_e;

  state_e            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic [WORD_W-1:0] a_rdata_q, b_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
    end
  end

  // A tie goes to whichever port was not granted most recently.
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    unique case (state_q)
      StIdle: begin
        if (a_req && (!b_req || last_b_q)) begin
          state_d  = StGrantA;
          last_b_d = 1'b0;
        end else if (b_req) begin
          state_d  = StGrantB;
          last_b_d = 1'b1;
        end
      end
      StGrantA: state_d = StAckA;
      StGrantB: state_d = StAckB;
      StAckA:   state_d = StIdle;
      StAckB:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ram_wb_en  = 1'b0;
    ram_r_en   = 1'b0;
    ram_addr   = '0;
    ram_d_in   = '0;
    ram_bit_en = '0;
    if (state_q == StGrantA) begin
      ram_wb_en  = 1'b1;
      ram_r_en   = ~a_we;
      ram_addr   = a_addr;
      ram_d_in   = a_wdata;
      ram_bit_en = a_ben;
    end else if (state_q == StGrantB) begin
      ram_wb_en  = 1'b1;
      ram_r_en   = ~b_we;
      ram_addr   = b_addr;
      ram_d_in   = b_wdata;
      ram_bit_en = b_ben;
    end
  end

  // Read data is captured at the edge that ends the grant and held until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (state_q == StGrantA && !a_we) a_rdata_q <= ram_d_out;
      if (state_q == StGrantB && !b_we) b_rdata_q <= ram_d_out;
    end
  end

  assign a_ack   = (state_q == StAckA);
  assign b_ack   = (state_q == StAckB);
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign busy    = (state_q != StIdle);

endmodule
